accum_sched: RTL and testbench

Round-robin scheduler that shares one saturating accumulator datapath among `NUM_REQ` requesters. Each requester submits a burst of samples over a valid/ready stream, terminated by `last`. The block grants one requester at a time, accumulates its burst from zero, and returns the sum with the requester ID and an overflow flag on a valid/ready result port. It sits between the sample producers and the downstream consumer of accumulated results.

---
 rtl/accum_sched_if.sv | 29 ++
 rtl/accum_sched.sv | 124 ++++++++++++
 tb/tb_accum_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_sched_if.sv
// rtl/accum_sched_if.sv - requester and result streams of the shared accumulator
// Producer/consumer side uses master, the scheduler uses slave.
interface accum_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8
) ();
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          res_valid;
  logic                          res_ready;
  logic [ACC_WIDTH-1:0]          res_data;
  logic [ID_WIDTH-1:0]           res_id;
  logic                          res_ovf;

  modport master (
    output req_valid, req_last, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_last, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_ovf
  );
endinterface

// File: rtl/accum_sched.sv
// rtl/accum_sched.sv - round-robin scheduler sharing one saturating accumulator
// One burst is accumulated at a time; the sum is returned with its owner ID.
module accum_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  accum_sched_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   pick;
  logic                  any_valid;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  ovf;
  logic [ACC_WIDTH-1:0]  res_data_q;
  logic [ID_WIDTH-1:0]   res_id_q;
  logic                  res_ovf_q;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat;
  logic                  beat_last;
  logic [ACC_WIDTH:0]    sum_wide;
  logic [ACC_WIDTH-1:0]  sum_sat;
  logic                  ovf_next;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin : pick_blk
    logic [ID_WIDTH-1:0] cand;
    pick      = rr_ptr;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        pick      = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign beat_data = data_arr[grant];
  assign beat      = (state == ACCUM) && bus.req_valid[grant];
  assign beat_last = bus.req_last[grant];
  assign sum_wide  = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, beat_data};
  assign sum_sat   = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
  assign ovf_next  = ovf | sum_wide[ACC_WIDTH];

  assign bus.req_ready = (state == ACCUM) ? (NUM_REQ'(1) << grant) : '0;
  assign bus.res_valid = (state == RESULT);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_ovf   = res_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = ACCUM;
      ACCUM:   if (beat && beat_last) state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant      <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= pick;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= sum_sat;
            ovf <= ovf_next;
            if (beat_last) begin
              res_data_q <= sum_sat;
              res_id_q   <= grant;
              res_ovf_q  <= ovf_next;
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            rr_ptr <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_sched.sv
// tb/tb_accum_sched.sv - self-checking bench for accum_sched
// Directed vector table, hand-written corner sequences, then randomized traffic against a burst-level model.
module tb_accum_sched;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
  accum_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int              id;
    int              n;
    logic [23:0][3:0] samp;
    int              gap_pos;
    int              gap_len;
    int              exp_sum;
    int              exp_ovf;
  } vec_t;

  vec_t vecs[5];
  int checks = 0;
  int failures = 0;

  // randomized-phase model state
  int samp_r [NR][24];
  int len_r [NR];
  int pos_r [NR];
  bit act_r [NR];
  int esum_r [NR];
  int eovf_r [NR];
  int done_id, done_sum, done_ovf;
  int m_ptr, started, results, onehot_bad, rdy_bad;
  bit expect_res, stop_new;
  logic [NR-1:0] prev_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int id, input int n, input int gp, input int gl,
                              input int es, input int eo);
    vec_t v;
    v.id = id; v.n = n; v.samp = '0; v.gap_pos = gp; v.gap_len = gl;
    v.exp_sum = es; v.exp_ovf = eo;
    return v;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic l, input int d);
    logic [NR*DW-1:0] mask;
    mask = (NR*DW)'((1 << DW) - 1) << (i * DW);
    bus.req_valid[i] = v;
    bus.req_last[i]  = l;
    bus.req_data     = (bus.req_data & ~mask) | (((NR*DW)'(d) << (i * DW)) & mask);
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int id, k, gcnt;
    bit fin;
    id = vecs[v].id; k = 0; gcnt = 0; fin = 0;
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (k == vecs[v].gap_pos && gcnt < vecs[v].gap_len) begin
        set_req(id, 1'b0, 1'b0, 0);
        gcnt++;
      end else begin
        set_req(id, 1'b1, k == vecs[v].n - 1, int'(vecs[v].samp[k]));
      end
      if (bus.req_ready[id] && bus.req_valid[id]) begin
        k++;
        fin = (k == vecs[v].n);
      end
      @(negedge clk);
    end
    set_req(id, 1'b0, 1'b0, 0);
    check($sformatf("vec%0d_done", v), 32'(fin), 1);
    check($sformatf("vec%0d_res_valid", v), 32'(bus.res_valid), 1);
    check($sformatf("vec%0d_data", v), 32'(bus.res_data), vecs[v].exp_sum);
    check($sformatf("vec%0d_id", v), 32'(bus.res_id), id);
    check($sformatf("vec%0d_ovf", v), 32'(bus.res_ovf), vecs[v].exp_ovf);
    @(negedge clk);
    check($sformatf("vec%0d_idle", v), 32'({bus.res_valid, bus.req_ready}), 0);
  endtask

  initial begin
    int ids [5];
    int datas [5];
    int nres, ob, bp_bad, k, len, total, s;
    int pos_f [NR];

    vecs[0] = mk(1, 3, -1, 0, 15, 0);
    vecs[0].samp[0] = 3; vecs[0].samp[1] = 5; vecs[0].samp[2] = 7;
    vecs[1] = mk(2, 20, -1, 0, 255, 1);
    for (int i = 0; i < 20; i++) vecs[1].samp[i] = 15;
    vecs[2] = mk(2, 2, -1, 0, 8, 0);
    vecs[2].samp[0] = 4; vecs[2].samp[1] = 4;
    vecs[3] = mk(3, 2, 1, 3, 11, 0);
    vecs[3].samp[0] = 2; vecs[3].samp[1] = 9;
    vecs[4] = mk(0, 1, -1, 0, 6, 0);
    vecs[4].samp[0] = 6;

    bus.res_ready = 1'b0;
    do_reset();
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    check("rst_res_ovf", 32'(bus.res_ovf), 0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // fairness: every requester keeps 2-beat bursts pending
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < NR; i++) pos_f[i] = 0;
    nres = 0; ob = 0;
    for (int cyc = 0; cyc < 100 && nres < 5; cyc++) begin
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, pos_f[i] == 1, 1);
      if ($countones(bus.req_ready) > 1) ob++;
      if (bus.res_valid) begin
        ids[nres] = int'(bus.res_id);
        datas[nres] = int'(bus.res_data);
        nres++;
      end
      for (int i = 0; i < NR; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) pos_f[i] = pos_f[i] ^ 1;
      @(negedge clk);
    end
    clear_inputs();
    check("fair_count", nres, 5);
    for (int r = 0; r < 5; r++) begin
      check($sformatf("fair_id%0d", r), ids[r], r % NR);
      check($sformatf("fair_data%0d", r), datas[r], 2);
    end
    check("fair_onehot", ob, 0);

    // result backpressure for five cycles, handshake on the sixth
    do_reset();
    bus.res_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      set_req(0, 1'b1, k == 1, (k == 0) ? 5 : 6);
      if (bus.req_ready[0] && bus.req_valid[0]) k++;
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 0);
    check("bp_data", 32'(bus.res_data), 11);
    bp_bad = 0;
    for (int c = 0; c < 5; c++) begin
      set_req(1, 1'b1, 1'b1, 3);
      if (!bus.res_valid || bus.res_data != 8'd11 || bus.res_id != 2'd0 || bus.req_ready != '0)
        bp_bad++;
      @(negedge clk);
    end
    set_req(1, 1'b0, 1'b0, 0);
    bus.res_ready = 1'b1;
    if (!bus.res_valid || bus.res_data != 8'd11) bp_bad++;
    check("bp_hold", bp_bad, 0);
    @(negedge clk);
    check("bp_idle", 32'({bus.res_valid, bus.req_ready}), 0);

    // randomized traffic against the burst-level model
    do_reset();
    m_ptr = 0; started = 0; results = 0; onehot_bad = 0; rdy_bad = 0;
    expect_res = 0; stop_new = 0; prev_ready = '0;
    for (int i = 0; i < NR; i++) begin act_r[i] = 0; pos_r[i] = 0; len_r[i] = 1; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 2500) stop_new = 1;
      if (stop_new && started == results && !bus.res_valid) break;
      if ($countones(bus.req_ready) > 1) onehot_bad++;
      if (bus.res_valid && bus.req_ready != '0) rdy_bad++;
      if (bus.req_ready != '0 && prev_ready == '0)
        check("rand_grant", oh_idx(bus.req_ready), rr_pick(m_ptr, bus.req_valid));
      if (expect_res) begin
        check("rand_res_latency", 32'(bus.res_valid), 1);
        expect_res = 0;
      end
      bus.res_ready = stop_new ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (bus.res_valid && bus.res_ready) begin
        check("rand_id", 32'(bus.res_id), done_id);
        check("rand_data", 32'(bus.res_data), done_sum);
        check("rand_ovf", 32'(bus.res_ovf), done_ovf);
        m_ptr = (done_id + 1) % NR;
        results++;
      end
      for (int i = 0; i < NR; i++) begin
        if (!act_r[i] && !stop_new && $urandom_range(0, 3) == 0) begin
          len = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
          total = 0;
          for (int j = 0; j < len; j++) begin
            s = (len == 20) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 15));
            samp_r[i][j] = s;
            total += s;
          end
          len_r[i] = len; pos_r[i] = 0; act_r[i] = 1;
          esum_r[i] = (total > 255) ? 255 : total;
          eovf_r[i] = (total > 255) ? 1 : 0;
          started++;
        end
        if (act_r[i])
          set_req(i, $urandom_range(0, 3) != 0, pos_r[i] == len_r[i] - 1, samp_r[i][pos_r[i]]);
        else
          set_req(i, 1'b0, 1'b0, 0);
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] && bus.req_valid[i]) begin
          if (pos_r[i] == len_r[i] - 1) begin
            done_id = i; done_sum = esum_r[i]; done_ovf = eovf_r[i];
            act_r[i] = 0; expect_res = 1;
          end else begin
            pos_r[i]++;
          end
        end
      end
      prev_ready = bus.req_ready;
      @(negedge clk);
    end
    clear_inputs();
    check("rand_all_results", results, started);
    check("rand_onehot", onehot_bad, 0);
    check("rand_ready_in_result", rdy_bad, 0);

    // reset two beats into a burst discards it
    bus.res_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      set_req(0, 1'b1, 1'b0, 4);
      if (bus.req_ready[0] && bus.req_valid[0]) k++;
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 0);
    check("mid_rst_in_accum", 32'(bus.req_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    check("mid_rst_res_valid", 32'(bus.res_valid), 0);
    check("mid_rst_res_data", 32'(bus.res_data), 0);
    check("mid_rst_res_id", 32'(bus.res_id), 0);
    check("mid_rst_res_ovf", 32'(bus.res_ovf), 0);
    run_vec(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
